// File: rtl/mem_to_apb_bridge.sv
// mem_to_apb_bridge
// Bridges a req/gnt/rvalid memory-style port onto a single APB3 master.
// Exactly one transfer is in flight at a time: IDLE -> SETUP -> ACCESS -> IDLE.
// A PREADY watchdog aborts an ACCESS phase that runs too long and returns
// an error response, so a hung slave cannot stall the requester.

module mem_to_apb_bridge #(
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // memory-style request/response port
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  // APB3 master port
  output logic [AddrWidth-1:0] paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  input  logic [31:0]          prdata_i,
  input  logic                 pready_i,
  input  logic                 pslverr_i
);

  // Watchdog sizing. A disabled watchdog still keeps a 1-bit counter so that
  // all vectors have a legal width; that counter then never moves.
  localparam bit WdEn = (TimeoutCycles > 0);
  localparam int CntW = WdEn ? $clog2(TimeoutCycles + 1) : 1;
  // Abort is decided in the last permitted ACCESS cycle, i.e. when the count of
  // already-elapsed wait cycles equals TimeoutCycles-1.
  localparam logic [CntW-1:0] CntLast = CntW'(WdEn ? (TimeoutCycles - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_e;

  state_e                 state_r;
  state_e                 state_s;

  logic [AddrWidth-1:0]   paddr_r;
  logic [AddrWidth-1:0]   paddr_s;
  logic                   pwrite_r;
  logic                   pwrite_s;
  logic [31:0]            pwdata_r;
  logic [31:0]            pwdata_s;
  logic [31:0]            rdata_r;
  logic [31:0]            rdata_s;
  logic                   err_r;
  logic                   err_s;
  logic                   rvalid_r;
  logic                   rvalid_s;
  logic [CntW-1:0]        cnt_r;
  logic [CntW-1:0]        cnt_s;
  logic                   gnt_s;

  // Byte lanes of the address are meaningless for 32-bit APB transfers.
  logic                   unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^addr_i[1:0];

  // State register; an asynchronous reset abandons any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, grant, captured request fields, response and watchdog count.
  always_comb begin
    state_s  = state_r;
    paddr_s  = paddr_r;
    pwrite_s = pwrite_r;
    pwdata_s = pwdata_r;
    rdata_s  = rdata_r;
    err_s    = err_r;
    rvalid_s = 1'b0;
    cnt_s    = cnt_r;
    gnt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        gnt_s = req_i;
        if (req_i) begin
          paddr_s  = {addr_i[AddrWidth-1:2], 2'b00};
          pwrite_s = we_i;
          pwdata_s = wdata_i;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_SETUP: begin
        // Counter starts from zero for every ACCESS phase.
        cnt_s   = '0;
        state_s = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          // Normal completion takes priority over a simultaneous timeout.
          rdata_s  = pwrite_r ? 32'h0000_0000 : prdata_i;
          err_s    = pslverr_i;
          rvalid_s = 1'b1;
          state_s  = ST_IDLE;
        end else if (WdEn && (cnt_r == CntLast)) begin
          rdata_s  = 32'h0000_0000;
          err_s    = 1'b1;
          rvalid_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          if (WdEn) begin
            cnt_s = cnt_r + CntW'(1);
          end else begin
            cnt_s = cnt_r;
          end
          state_s = ST_ACCESS;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered request fields, response and watchdog counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_r  <= '0;
      pwrite_r <= 1'b0;
      pwdata_r <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
      err_r    <= 1'b0;
      rvalid_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      paddr_r  <= paddr_s;
      pwrite_r <= pwrite_s;
      pwdata_r <= pwdata_s;
      rdata_r  <= rdata_s;
      err_r    <= err_s;
      rvalid_r <= rvalid_s;
      cnt_r    <= cnt_s;
    end
  end

  // Grant is combinational from req_i while idle so a new request can be
  // accepted in the same cycle the previous response is presented.
  assign gnt_o     = gnt_s;
  assign rvalid_o  = rvalid_r;
  assign rdata_o   = rdata_r;
  assign err_o     = err_r;
  assign paddr_o   = paddr_r;
  assign pwrite_o  = pwrite_r;
  assign pwdata_o  = pwdata_r;
  assign psel_o    = (state_r == ST_SETUP) || (state_r == ST_ACCESS);
  assign penable_o = (state_r == ST_ACCESS);

endmodule

// File: tb/tb_mem_to_apb_bridge.sv
// Testbench for mem_to_apb_bridge: directed cases plus randomized transfers.
// A driver issues requests and pushes expected responses; an APB slave model
// answers with a chosen number of wait states; a monitor pops and compares
// each response when rvalid_o is seen.

module tb_mem_to_apb_bridge;

  localparam int AW = 32;
  localparam int T  = 16;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] paddr_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [31:0]   pwdata_o;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  mem_to_apb_bridge #(.AddrWidth(AW), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rd;
    logic        se;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      cyc;
  } resp_t;

  txn_t   slave_q[$];
  resp_t  exp_q[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;
  bit     chain = 1'b0;
  longint prev_rv = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     {63'd0, gnt_o},     64'd0);
    chk({tag, "_rvalid"},  {63'd0, rvalid_o},  64'd0);
    chk({tag, "_rdata"},   {32'd0, rdata_o},   64'd0);
    chk({tag, "_err"},     {63'd0, err_o},     64'd0);
    chk({tag, "_paddr"},   {32'd0, paddr_o},   64'd0);
    chk({tag, "_psel"},    {63'd0, psel_o},    64'd0);
    chk({tag, "_penable"}, {63'd0, penable_o}, 64'd0);
    chk({tag, "_pwrite"},  {63'd0, pwrite_o},  64'd0);
    chk({tag, "_pwdata"},  {32'd0, pwdata_o},  64'd0);
  endtask

  // Issue one request (called just after a rising edge). Expected response is
  // derived from the wait count: the slave answers on ACCESS cycle waits+1;
  // if that exceeds T cycles the watchdog answers with an error instead.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input logic se,
                       input bit hold, input bit expect_resp);
    txn_t  t;
    resp_t r;
    int    budget;
    req = 1'b1; we = w; addr = a; wdata = wd;
    budget = 0;
    @(negedge clk);
    while (gnt_o !== 1'b1 && budget < 60) begin
      budget++;
      @(negedge clk);
    end
    if (gnt_o !== 1'b1) begin
      chk("grant_timeout", 64'd0, 64'd1);
    end else begin
      if (chain) chk("b2b_grant_cycle", cyc, prev_rv);
      t.addr = a; t.we = w; t.wdata = wd; t.waits = waits; t.rd = rd; t.se = se;
      slave_q.push_back(t);
      if (waits < T) begin
        r.rdata = w ? 32'd0 : rd;
        r.err   = se;
        r.cyc   = cyc + waits + 3;
      end else begin
        r.rdata = 32'd0;
        r.err   = 1'b1;
        r.cyc   = cyc + T + 2;
      end
      if (expect_resp) exp_q.push_back(r);
      prev_rv = r.cyc;
    end
    @(posedge clk);
    #1;
    chain = hold;
    if (!hold) begin
      req = 1'b0; addr = $urandom; we = $urandom_range(0, 1); wdata = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // APB slave model; also checks that request fields stay stable and no
  // grant is given while a transfer is in flight.
  initial begin
    txn_t cur;
    int   k;
    cur = '{default: 0};
    k = 0;
    pready = 1'b0; prdata = 32'd0; pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (psel_o === 1'b1 && penable_o === 1'b0) begin
        if (slave_q.size() == 0) begin
          chk("apb_unexpected_setup", 64'd1, 64'd0);
        end else begin
          cur = slave_q.pop_front();
        end
        k = 0;
        chk("setup_paddr",  {32'd0, paddr_o},  {32'd0, cur.addr & 32'hFFFF_FFFC});
        chk("setup_pwrite", {63'd0, pwrite_o}, {63'd0, cur.we});
        chk("setup_pwdata", {32'd0, pwdata_o}, {32'd0, cur.wdata});
        chk("setup_gnt",    {63'd0, gnt_o},    64'd0);
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end else if (psel_o === 1'b1 && penable_o === 1'b1) begin
        chk("access_paddr",  {32'd0, paddr_o},  {32'd0, cur.addr & 32'hFFFF_FFFC});
        chk("access_pwrite", {63'd0, pwrite_o}, {63'd0, cur.we});
        chk("access_pwdata", {32'd0, pwdata_o}, {32'd0, cur.wdata});
        chk("access_gnt",    {63'd0, gnt_o},    64'd0);
        if (k == cur.waits) begin
          pready = 1'b1; prdata = cur.rd; pslverr = cur.se;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
        end
        k++;
      end else begin
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", 64'd1, 64'd0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", {32'd0, rdata_o}, {32'd0, e.rdata});
        chk("resp_err",   {63'd0, err_o},   {63'd0, e.err});
        chk("resp_cycle", cyc,              e.cyc);
      end
    end
  end

  initial begin
    int waits_tab[8];
    int budget;
    waits_tab = '{0, 1, 2, 3, 7, 15, 16, 25};
    rst_n = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1 rst_n = 1'b0;
    #20;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1. write, zero wait states
    issue(32'h0, 1'b1, 32'h41, 0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(4);
    // 2. read, unaligned address
    issue(32'h16, 1'b0, 32'h0, 0, 32'h60, 1'b0, 1'b0, 1'b1);
    idle(4);
    // 3. five wait states
    issue($urandom, 1'b0, $urandom, 5, $urandom, 1'b0, 1'b0, 1'b1);
    idle(10);
    // 4. watchdog abort, then a chained request is granted
    issue($urandom, 1'b0, $urandom, 100, $urandom, 1'b0, 1'b1, 1'b1);
    // 5. slave error followed by back-to-back zero-wait transfers
    issue($urandom, 1'b0, $urandom, 0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
    issue($urandom, 1'b1, $urandom, 0, $urandom, 1'b0, 1'b1, 1'b1);
    issue($urandom, 1'b0, $urandom, 0, $urandom, 1'b0, 1'b1, 1'b1);
    issue($urandom, 1'b0, $urandom, 15, $urandom, 1'b1, 1'b0, 1'b1);
    idle(20);

    // 6. reset in the middle of an ACCESS phase
    issue($urandom, 1'b0, $urandom, 50, $urandom, 1'b0, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    chain = 1'b0;
    idle(6);
    issue(32'h0000_1238, 1'b0, $urandom, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      issue($urandom, 1'($urandom_range(0, 1)), $urandom, waits_tab[$urandom_range(0, 7)],
            $urandom, 1'($urandom_range(0, 1)), h, 1'b1);
      if (!h) idle($urandom_range(0, 3));
    end
    chain = 1'b0;
    req = 1'b0;

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    idle(3);
    chk("drain_exp_q", exp_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
